// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its priority encoder.
// Kept as a package so the encoder can be reused elsewhere in the datapath.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Pointer arithmetic wraps naturally in IDX_W bits (7 + 1 -> 0).
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins.
// invalid flags an all-zero input, in which case idx is 0.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             invalid
);

  always_comb begin
    idx = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i[IDX_W-1:0];
      end
    end
  end

  assign invalid = ~|vec;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with an optional hold-time limit.
// All outputs are registered; priority rotates one past the last owner.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             revoke
);

  // With the limit disabled the counter simply saturates at all-ones.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               gnt_valid_q;
  logic               revoke_q;
  logic [HOLD_W-1:0]  hold_q;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_invalid;
  logic [IDX_W-1:0]   winner_d;
  logic [N_REQ-1:0]   gnt_d;
  logic               owner_wd;
  logic               lim_hit;
  logic               grant_end;

  // Rotate right by ptr so the pointer position lands at bit 0.
  assign req_dbl = {req, req} >> ptr_q;
  assign req_rot = req_dbl[N_REQ-1:0];

  prio_enc8 u_enc (
    .vec     (req_rot),
    .idx     (enc_idx),
    .invalid (enc_invalid)
  );

  assign winner_d  = enc_idx + ptr_q;
  assign gnt_d     = {{(N_REQ-1){1'b0}}, 1'b1} << winner_d;

  assign owner_wd  = ~req[idx_q];
  assign lim_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign grant_end = rel | owner_wd | lim_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      revoke_q    <= 1'b0;
      hold_q      <= '0;
    end else begin
      revoke_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!enc_invalid) begin
            gnt_q       <= gnt_d;
            idx_q       <= winner_d;
            gnt_valid_q <= 1'b1;
            hold_q      <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (grant_end) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= next_ptr(idx_q);
            state_q     <= IDLE;
            // A voluntary end (release or withdrawal) masks the forced one.
            revoke_q    <= lim_hit & ~rel & ~owner_wd;
          end else if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = gnt_valid_q;
  assign revoke    = revoke_q;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter granting one shared resource to one of eight requesters. It rotates priority with a pointer and runs the masked request vector through an 8-to-3 priority encoder. Each grant is held until the owner releases it or a hold-time limit expires. It sits between the requester ports and the shared datapath and drives the resource's select and enable.

## Interface
- MAX_HOLD, default 16: maximum cycles one grant may be held. 0 disables the limit.
- HOLD_W, default 5: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; reset is asynchronous and active-low.
- req  in  8  request vector; bit i set means requester i wants the resource.
- rel  in  1  release strobe from the current owner, sampled only while granted.
- gnt  out  8  one-hot grant, registered.
- gnt_idx  out  3  binary index of the owner. Valid only when gnt_valid is 1.
- gnt_valid  out  1  high while a grant is held. Equals the OR of gnt.
- revoke  out  1  one-cycle pulse when a grant is forcibly ended by the hold limit.

## Operation
- Two states, IDLE and GRANT. Reset enters IDLE.
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, revoke=0, pointer ptr=0, hold counter=0.
- IDLE, arbitration:
  - Rotate req right by ptr.
  - Priority-encode the result, lowest bit wins.
  - winner = (encoded + ptr) mod 8.
- IDLE, outcome:
  - If any req bit is set: register gnt = 1<<winner, gnt_idx = winner, gnt_valid = 1, clear the hold counter, go to GRANT.
  - If no req bit is set (encoder invalid): stay in IDLE, outputs 0.
- GRANT ends normally on any of these:
  - rel = 1;
  - req[gnt_idx] = 0 (owner withdrew);
  - MAX_HOLD ≠ 0 and hold counter = MAX_HOLD-1.
- On any GRANT end:
  - Next cycle gnt = 0, gnt_valid = 0.
  - gnt_idx keeps the old value.
  - ptr = (gnt_idx + 1) mod 8.
  - Return to IDLE.
- Forced end: revoke = 1 for exactly one cycle only when the hold limit ended the grant and neither rel nor the owner withdrawal was present in that cycle. Release has precedence.
- Otherwise GRANT holds all outputs and the hold counter increments, saturating at MAX_HOLD-1.
- Changes on non-owner req bits while in GRANT are ignored.
- Pointer arithmetic is 3-bit modulo 8. ptr=7 with owner 7 wraps to 0.
- rel while in IDLE is ignored.

## Timing
- Grant latency: req seen in IDLE at edge N → gnt high after edge N.
- Release latency: rel high at edge M → gnt low after edge M.
- Exactly one IDLE cycle between consecutive grants, so the minimum grant period is 2 cycles.
- A grant with MAX_HOLD=K lasts at most K cycles of gnt_valid=1.
- revoke is coincident with the first cycle of gnt_valid=0.
- Asynchronous reset during GRANT clears every output immediately; ptr returns to 0.
- Reset deassertion is synchronised externally; the block needs no extra cycle after it.
- No combinational path from any input to any output.

## Structure
- Shared package arb_pkg:
  - N_REQ = 8;
  - IDX_W = 3;
  - state encoding IDLE = 1'b0, GRANT = 1'b1.
- One sub-module, prio_enc8:
  - combinational 8-to-3, lowest-index priority;
  - outputs idx[2:0] and invalid (invalid = 1 when the input is 0).
  - The same encoder is used elsewhere in the datapath.
- Top level holds the rotation, FSM, pointer and hold counter. Estimated 150–250 lines of RTL total.

## Test plan
- Reset mid-grant:
  - Stimulus: req=8'h10 held for 3 cycles, then rst_n=0.
  - Required: gnt=0, gnt_valid=0 asynchronously.
  - After release with req=8'h11: grant to 0 (ptr=0).
- Fairness:
  - Stimulus: req=8'hFF held, rel pulsed each GRANT cycle.
  - Required: gnt_idx sequence 0,1,2,…,7,0 with an IDLE cycle between each grant.
- Wrap-around:
  - Stimulus: ptr=7 after owner 6, then req=8'h81.
  - Required: grant 7; after release, grant 0.
- Hold limit:
  - Stimulus: MAX_HOLD=4, req=8'h04 held, rel never asserted.
  - Required: gnt_valid high for exactly 4 cycles, revoke pulses once, re-grant to 2 one cycle later.
- Simultaneous events:
  - Stimulus: rel and the hold limit in the same cycle.
  - Required: revoke stays 0, ptr advances.
- Withdrawal and idle:
  - Stimulus: owner drops req mid-grant.
  - Required: gnt drops next cycle.
  - Stimulus: req=0 for 10 cycles.
  - Required: gnt_valid stays 0, ptr unchanged.
